// File: rtl/fpu_issue_ctrl_pkg.sv
// FPU issue control: shared encodings, state type and helpers.
// Op selects, core op codes, states, canonical NaN.
package fpu_issue_ctrl_pkg;

  localparam logic [2:0] FPU_ADD  = 3'd0;
  localparam logic [2:0] FPU_SGNJ = 3'd1;
  localparam logic [2:0] FPU_ASEL = 3'd2;
  localparam logic [2:0] FPU_CVT  = 3'd3;
  localparam logic [2:0] FPU_MADD = 3'd4;
  localparam logic [2:0] FPU_BSEL = 3'd5;

  localparam logic [1:0] CORE_OP_ADD  = 2'b00;
  localparam logic [1:0] CORE_OP_CVT  = 2'b01;
  localparam logic [1:0] CORE_OP_MADD = 2'b10;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  function automatic logic is_remote(input logic [2:0] sel);
    return (sel == FPU_ADD) || (sel == FPU_CVT) || (sel == FPU_MADD);
  endfunction

  function automatic logic [1:0] core_op_of(input logic [2:0] sel);
    logic [1:0] op;
    op = CORE_OP_ADD;
    unique case (1'b1)
      sel == FPU_CVT:  op = CORE_OP_CVT;
      sel == FPU_MADD: op = CORE_OP_MADD;
      default:         op = CORE_OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_local_ops.sv
// Single-cycle FPU ops: sign-inject, A-move, B-pass.
// In: fpusel, sgnj_mode, op_a, op_b. Out: is_local, res.
import fpu_issue_ctrl_pkg::*;

module fpu_local_ops (
  input  logic [2:0]  fpusel,
  input  logic [1:0]  sgnj_mode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        is_local,
  output logic [31:0] res
);

  logic sgn;

  always_comb begin
    sgn = op_b[31];
    unique case (sgnj_mode)
      2'b01:   sgn = ~op_b[31];
      2'b10:   sgn = op_a[31] ^ op_b[31];
      default: sgn = op_b[31];
    endcase
  end

  always_comb begin
    is_local = 1'b1;
    res      = '0;
    unique case (1'b1)
      fpusel == FPU_SGNJ: res = {sgn, op_a[30:0]};
      fpusel == FPU_ASEL: res = op_a;
      fpusel == FPU_BSEL: res = op_b;
      default:            is_local = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Execute-stage FPU responder: local ops inline, multi-cycle ops via core.
// Ports: fpu_valid/fpusel/ops in, stall/busy/result out, core req/ack/resp.
import fpu_issue_ctrl_pkg::*;

module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fpu_valid,
  input  logic [2:0]  fpusel,
  input  logic [1:0]  sgnj_mode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] op_c,
  input  logic        kill,
  output logic        stall,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        err,
  output logic        core_req,
  output logic [1:0]  core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [31:0] core_c,
  input  logic        core_ack,
  input  logic        core_resp_valid,
  input  logic [31:0] core_resp_data
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             rv_q;
  logic             loc;
  logic [31:0]      loc_res;
  logic             tmo;

  fpu_local_ops u_local (
    .fpusel    (fpusel),
    .sgnj_mode (sgnj_mode),
    .op_a      (op_a),
    .op_b      (op_b),
    .is_local  (loc),
    .res       (loc_res)
  );

  assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign stall = rst_n &
    ((state == S_IDLE & fpu_valid & is_remote(fpusel)) |
     state == S_ISSUE | state == S_WAIT);

  assign busy = (state != S_IDLE);

  // kill masks a completion in the very cycle it is presented
  assign result_valid = rv_q & ~kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rv_q     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      core_req <= 1'b0;
      core_op  <= '0;
      core_a   <= '0;
      core_b   <= '0;
      core_c   <= '0;
    end else begin
      rv_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fpu_valid && !kill) begin
            if (loc) begin
              result <= loc_res;
              rv_q   <= 1'b1;
            end else if (is_remote(fpusel)) begin
              core_a   <= op_a;
              core_b   <= op_b;
              core_c   <= op_c;
              core_op  <= core_op_of(fpusel);
              core_req <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (kill) begin
            core_req <= 1'b0;
            cnt      <= '0;
            state    <= core_ack ? S_DRAIN : S_IDLE;
          end else if (core_ack) begin
            core_req <= 1'b0;
            cnt      <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (kill) begin
            // a response landing with the kill is consumed and dropped
            if (core_resp_valid) begin
              state <= S_IDLE;
            end else if (tmo) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= S_DRAIN;
            end
          end else if (core_resp_valid) begin
            result <= core_resp_data;
            rv_q   <= 1'b1;
            state  <= S_DONE;
          end else if (tmo) begin
            result <= FP_CANON_NAN;
            err    <= 1'b1;
            rv_q   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (core_resp_valid) begin
            state <= S_IDLE;
          end else if (tmo) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Responder for the execute-stage FPU request interface: `fpu_valid` pulse with `fpusel` opcode and operands. The execute-stage control raises `fpu_valid` once per new instruction.
- Executes single-cycle ops (sign-inject, A-move, B-pass) locally.
- Dispatches multi-cycle ops (ADD, CVT, MADD) to the pipelined FP core through a req/ack + response handshake.
- Stalls the pipeline until the result is available. Sits between execute-stage control and the FP datapath core.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT before forced error completion.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fpu_valid  in  1  one-cycle request pulse from execute control
- fpusel  in  3  FPU op select, encodings from control_sel.vh
- sgnj_mode  in  2  inst[13:12]: 00 J, 01 JN, 10 JX, 11 treated as J
- op_a, op_b, op_c  in  32  operands (rs1/frs1, frs2/rs2, frs3)
- kill  in  1  pipeline flush; aborts in-flight op
- stall  out  1  hold pipeline
- busy  out  1  state != IDLE
- result  out  32  FP/int result
- result_valid  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag
- core_req  out  1  request to FP core
- core_op  out  2  00 ADD, 01 CVT, 10 MADD
- core_a, core_b, core_c  out  32  latched operands
- core_ack  in  1  core accepted request
- core_resp_valid  in  1  core result strobe
- core_resp_data  in  32  core result

Behaviour:
- Reset values of registered outputs: state IDLE; result=0, result_valid=0, err=0, core_req=0, core_op=0, core_a/b/c=0, counter=0. `stall` and `busy` are combinational and read 0 while in reset.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE, `fpu_valid` & local op:
  - SGNJ: result = {sign', op_a[30:0]}, where sign' = op_b[31] (J), ~op_b[31] (JN), op_a[31]^op_b[31] (JX).
  - ASEL: result = op_a. BSEL: result = op_b.
  - result registered; result_valid high next cycle; state stays IDLE; stall never asserted. Latency 1.
- IDLE, `fpu_valid` & remote op (ADD/CVT/MADD):
  - latch operands and core_op; go to ISSUE.
  - stall=1 combinationally in the accept cycle.
- IDLE, undefined fpusel (6, 7): ignored, no result.
- ISSUE: core_req=1, operands held stable. On core_ack go to WAIT and clear the counter. An ack in the same cycle as req counts.
- WAIT: counter increments each cycle.
  - On core_resp_valid: capture core_resp_data into result; go to DONE.
  - On counter==TIMEOUT_CYCLES-1 without a response: result=0x7FC00000 (canonical NaN), err<=1; go to DONE.
- DONE: result_valid=1 for this cycle; stall=0; next state IDLE.
- stall = (IDLE & fpu_valid & remote op) | ISSUE | WAIT.
- fpu_valid in any non-IDLE state is ignored; no queueing.
- kill handling:
  - Takes priority over all else. Forces result_valid low for that cycle.
  - IDLE with simultaneous fpu_valid: request dropped.
  - ISSUE with no ack this cycle: core_req drops next cycle; go to IDLE.
  - ISSUE with ack this cycle, or WAIT: go to DRAIN.
  - DONE: result_valid suppressed; go to IDLE.
- DRAIN: stall=0, but any fpu_valid arriving is ignored. On core_resp_valid or timeout go to IDLE, discarding data; timeout still sets err.
- core_resp_valid outside WAIT/DRAIN is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The core is expected to be reset on the same rst_n.

Decomposition:
- control_sel.vh: FPU_ADD=3'd0, FPU_SGNJ=3'd1, FPU_ASEL=3'd2, FPU_CVT=3'd3, FPU_MADD=3'd4, FPU_BSEL=3'd5; CORE_OP_ADD/CVT/MADD; state encodings; FP_CANON_NAN=32'h7FC00000.
- One sub-module: fpu_local_ops, combinational SGNJ/ASEL/BSEL selection, instantiated once.

Test Plan:
- fpu_valid, SGNJ JX, op_a=0xBF800000, op_b=0x80000000 -> next cycle result_valid=1, result=0x3F800000; stall stays 0.
- fpu_valid, ADD; core_ack after 2 cycles; core_resp_valid with 0x40400000 3 cycles later -> stall high from the accept cycle through WAIT; one result_valid pulse with result=0x40400000; core_a/b held stable in ISSUE.
- MADD, core never responds -> after TIMEOUT_CYCLES in WAIT: result=0x7FC00000, err=1, stall drops, err stays 1 on later ops.
- CVT acked, kill in WAIT; new fpu_valid ADD during DRAIN; core_resp_valid arrives -> no result_valid, ADD ignored, state back to IDLE, core_req not reasserted.
- kill same cycle as core_ack in ISSUE -> DRAIN entered; subsequent response discarded.
- rst_n low mid-WAIT -> all outputs 0 asynchronously; after release, BSEL op_b=0x12345678 -> result=0x12345678 with latency 1.
